// File: rtl/core_mem_arbiter_if.sv
// Core memory port bundle: fetch and data requesters plus the shared bus.
// master is the arbiter's view, slave the surrounding pipeline/bus view.
interface core_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_err;
  logic [DATA_W-1:0] imem_rdata;

  logic                dmem_req;
  logic                dmem_wen;
  logic [DATA_W/8-1:0] dmem_strb;
  logic [ADDR_W-1:0]   dmem_addr;
  logic [DATA_W-1:0]   dmem_wdata;
  logic                dmem_gnt;
  logic                dmem_recv;
  logic                dmem_err;
  logic [DATA_W-1:0]   dmem_rdata;

  logic                m_req;
  logic                m_wen;
  logic [DATA_W/8-1:0] m_strb;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic                m_gnt;
  logic                m_err;
  logic [DATA_W-1:0]   m_rdata;

  modport master (
    input  imem_req, imem_addr,
    output imem_gnt, imem_err, imem_rdata,
    input  dmem_req, dmem_wen, dmem_strb,
    input  dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_recv, dmem_err,
    output dmem_rdata,
    output m_req, m_wen, m_strb, m_addr,
    output m_wdata,
    input  m_gnt, m_err, m_rdata
  );

  modport slave (
    output imem_req, imem_addr,
    input  imem_gnt, imem_err, imem_rdata,
    output dmem_req, dmem_wen, dmem_strb,
    output dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_recv, dmem_err,
    input  dmem_rdata,
    input  m_req, m_wen, m_strb, m_addr,
    input  m_wdata,
    output m_gnt, m_err, m_rdata
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Fetch/data arbiter for the single core memory port.
// CORE_MEM_ARB_RR_EN: round-robin contention instead of dmem priority.
module core_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 g_clk,
  input logic                 g_resetn,
  core_mem_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_I,
    LOCK_D
  } state_e;

  state_e state_q, state_d;

  logic sel_i, sel_d, pick_d;
  logic rsp_v_q, rsp_v_d;
  logic rsp_own_q, rsp_own_d;

  logic                m_req_c;
  logic                m_wen_c;
  logic [DATA_W/8-1:0] m_strb_c;
  logic [ADDR_W-1:0]   m_addr_c;
  logic [DATA_W-1:0]   m_wdata_c;
  logic                igrant, dgrant;

`ifdef CORE_MEM_ARB_RR_EN
  logic last_own_q, last_own_d;

  // dmem wins contention only if imem owned the last grant
  always_comb pick_d = !last_own_q;

  always_comb begin
    last_own_d = last_own_q;
    if (igrant) last_own_d = 1'b0;
    else if (dgrant) last_own_d = 1'b1;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) last_own_q <= 1'b1;
    else           last_own_q <= last_own_d;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  always_comb pick_d = (starve_q != LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (igrant || !bus.imem_req)
      starve_d = '0;
    else if (dgrant && starve_q != LIMIT)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) starve_q <= '0;
    else           starve_q <= starve_d;
  end
`endif

  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    case (state_q)
      LOCK_I: sel_i = 1'b1;
      LOCK_D: sel_d = 1'b1;
      default: begin
        if (bus.imem_req && bus.dmem_req) begin
          sel_d = pick_d;
          sel_i = !pick_d;
        end else begin
          sel_i = bus.imem_req;
          sel_d = bus.dmem_req;
        end
      end
    endcase
  end

  always_comb begin
    m_req_c   = (sel_i & bus.imem_req) | (sel_d & bus.dmem_req);
    m_wen_c   = sel_d & bus.dmem_wen;
    m_strb_c  = sel_d ? bus.dmem_strb  : '0;
    m_wdata_c = sel_d ? bus.dmem_wdata : '0;
    m_addr_c  = '0;
    unique case (1'b1)
      sel_d:   m_addr_c = bus.dmem_addr;
      sel_i:   m_addr_c = bus.imem_addr;
      default: m_addr_c = '0;
    endcase
  end

  assign igrant = bus.m_gnt & sel_i & bus.imem_req;
  assign dgrant = bus.m_gnt & sel_d & bus.dmem_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (m_req_c && !bus.m_gnt)
          state_d = sel_d ? LOCK_D : LOCK_I;
      LOCK_I:
        if (!bus.imem_req || bus.m_gnt) state_d = IDLE;
      LOCK_D:
        if (!bus.dmem_req || bus.m_gnt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_v_d   = m_req_c & bus.m_gnt;
    rsp_own_d = sel_d;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= IDLE;
      rsp_v_q   <= 1'b0;
      rsp_own_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_v_q   <= rsp_v_d;
      rsp_own_q <= rsp_own_d;
    end
  end

  assign bus.m_req   = m_req_c;
  assign bus.m_wen   = m_wen_c;
  assign bus.m_strb  = m_strb_c;
  assign bus.m_addr  = m_addr_c;
  assign bus.m_wdata = m_wdata_c;

  assign bus.imem_gnt   = igrant;
  assign bus.dmem_gnt   = dgrant;
  assign bus.imem_rdata = bus.m_rdata;
  assign bus.dmem_rdata = bus.m_rdata;
  assign bus.imem_err   = bus.m_err & rsp_v_q & !rsp_own_q;
  assign bus.dmem_recv  = rsp_v_q & rsp_own_q;
  assign bus.dmem_err   = bus.m_err & rsp_v_q & rsp_own_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed plus randomized check of core_mem_arbiter against
// a transaction-level reference model.
module tb_core_mem_arbiter;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  core_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  core_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIM)
  ) dut (
    .g_clk(clk),
    .g_resetn(rstn),
    .bus(bus)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // model: owner of a pending lock, last response owner, fairness
  int m_lock;
  int m_prev;
  int m_starve;
  int m_last;
  logic e_ig, e_dg;
  logic o_ig, o_dg;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input string obs, input string exp);
    cmp_cnt++;
    assert (obs == exp) else begin
      err_cnt++;
      $error("FAIL %s: got %s expected %s", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    bus.imem_req   = 1'b0;
    bus.imem_addr  = '0;
    bus.dmem_req   = 1'b0;
    bus.dmem_wen   = 1'b0;
    bus.dmem_strb  = '0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.m_gnt      = 1'b0;
    bus.m_err      = 1'b0;
    bus.m_rdata    = '0;
  endtask

  task automatic model_reset();
    m_lock   = -1;
    m_prev   = -1;
    m_starve = 0;
    m_last   = 1;
  endtask

  task automatic do_reset();
    clr_inputs();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // checks one cycle of outputs, then advances the model past the edge
  task automatic step();
    int who;
    logic ir, dr, mg, e_req;
    logic [63:0] e_addr;
    #1;
    ir = bus.imem_req;
    dr = bus.dmem_req;
    mg = bus.m_gnt;
    if (m_lock >= 0) who = m_lock;
    else if (ir && dr) begin
`ifdef CORE_MEM_ARB_RR_EN
      who = (m_last == 1) ? 0 : 1;
`else
      who = (m_starve == LIM) ? 0 : 1;
`endif
    end
    else if (ir) who = 0;
    else if (dr) who = 1;
    else who = -1;
    e_req  = (who == 0) ? ir : (who == 1) ? dr : 1'b0;
    e_addr = (who == 0) ? bus.imem_addr :
             (who == 1) ? bus.dmem_addr : 64'd0;
    e_ig = mg && who == 0 && ir;
    e_dg = mg && who == 1 && dr;
    o_ig = bus.imem_gnt;
    o_dg = bus.dmem_gnt;
    chk1("m_req", bus.m_req, e_req);
    chk64("m_addr", bus.m_addr, e_addr);
    chk1("m_wen", bus.m_wen, who == 1 && bus.dmem_wen);
    chk64("m_strb", 64'(bus.m_strb),
          (who == 1) ? 64'(bus.dmem_strb) : 64'd0);
    if (who == 1) chk64("m_wdata", bus.m_wdata, bus.dmem_wdata);
    if (who == -1) chk64("m_wdata_idle", bus.m_wdata, 64'd0);
    chk1("imem_gnt", bus.imem_gnt, e_ig);
    chk1("dmem_gnt", bus.dmem_gnt, e_dg);
    chk1("imem_err", bus.imem_err, bus.m_err && m_prev == 0);
    chk1("dmem_recv", bus.dmem_recv, m_prev == 1);
    chk1("dmem_err", bus.dmem_err, bus.m_err && m_prev == 1);
    chk64("imem_rdata", bus.imem_rdata, bus.m_rdata);
    chk64("dmem_rdata", bus.dmem_rdata, bus.m_rdata);
    @(posedge clk);
    m_prev = (e_req && mg) ? who : -1;
    if (m_lock < 0) begin
      if (e_req && !mg) m_lock = who;
    end else if (m_lock == 0) begin
      if (!ir || mg) m_lock = -1;
    end else begin
      if (!dr || mg) m_lock = -1;
    end
    if (e_ig || !ir) m_starve = 0;
    else if (e_dg && m_starve < LIM) m_starve = m_starve + 1;
    if (e_ig) m_last = 0;
    else if (e_dg) m_last = 1;
    @(negedge clk);
  endtask

  initial begin
    string seq;
    logic pend_i, pend_d;
    model_reset();
    clr_inputs();
    #12;
    do_reset();

    // reset state
    step();
    chk1("rst_m_req", bus.m_req, 1'b0);
    chk64("rst_m_addr", bus.m_addr, 64'd0);

    // fetch alone, then error response
    bus.imem_req  = 1'b1;
    bus.imem_addr = 64'h8000_0000;
    bus.m_gnt     = 1'b1;
    #1;
    chk64("fetch_addr", bus.m_addr, 64'h8000_0000);
    chk1("fetch_gnt", bus.imem_gnt, 1'b1);
    step();
    bus.imem_req = 1'b0;
    bus.m_gnt    = 1'b0;
    bus.m_err    = 1'b1;
    #1;
    chk1("fetch_err", bus.imem_err, 1'b1);
    chk1("fetch_recv", bus.dmem_recv, 1'b0);
    step();

    // contention with m_gnt held high
    do_reset();
    bus.imem_req  = 1'b1;
    bus.imem_addr = 64'h100;
    bus.dmem_req  = 1'b1;
    bus.dmem_addr = 64'h200;
    bus.m_gnt     = 1'b1;
    seq = "";
    for (int i = 0; i < 6; i++) begin
      step();
      seq = {seq, o_ig ? "I" : o_dg ? "D" : "-"};
    end
`ifdef CORE_MEM_ARB_RR_EN
    chks("contention_order", seq, "IDIDID");
`else
    chks("contention_order", seq, "DDDDID");
`endif

    // lock hold on a stalled dmem write
    do_reset();
    bus.dmem_req   = 1'b1;
    bus.dmem_wen   = 1'b1;
    bus.dmem_addr  = 64'h1000;
    bus.dmem_strb  = 8'hFF;
    bus.dmem_wdata = 64'hDEAD_BEEF_0123_4567;
    step();
    bus.imem_req  = 1'b1;
    bus.imem_addr = 64'h4000;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk64("lock_addr", bus.m_addr, 64'h1000);
      step();
    end
    bus.m_gnt = 1'b1;
    step();
    bus.dmem_req = 1'b0;
    #1;
    chk1("lock_next_ig", bus.imem_gnt, 1'b1);
    step();

    // fetch withdrawal from LOCK_I
    do_reset();
    bus.imem_req  = 1'b1;
    bus.imem_addr = 64'h2000;
    step();
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b1;
    bus.dmem_addr = 64'h3000;
    #1;
    chk1("withdraw_mreq", bus.m_req, 1'b0);
    step();
    bus.m_gnt = 1'b1;
    #1;
    chk1("withdraw_dgnt", bus.dmem_gnt, 1'b1);
    step();

    // back-to-back routing
    do_reset();
    bus.imem_req = 1'b1;
    bus.m_gnt    = 1'b1;
    step();
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b1;
    bus.m_err    = 1'b1;
    #1;
    chk1("b2b_ierr", bus.imem_err, 1'b1);
    chk1("b2b_recv0", bus.dmem_recv, 1'b0);
    step();
    bus.dmem_req = 1'b0;
    bus.m_err    = 1'b0;
    #1;
    chk1("b2b_recv1", bus.dmem_recv, 1'b1);
    chk1("b2b_ierr0", bus.imem_err, 1'b0);
    step();
    chk1("b2b_recv2", bus.dmem_recv, 1'b0);

    // async reset with a response pending
    do_reset();
    bus.dmem_req = 1'b1;
    bus.m_gnt    = 1'b1;
    step();
    bus.m_gnt = 1'b0;
    bus.m_err = 1'b1;
    #1;
    chk1("arst_recv_pre", bus.dmem_recv, 1'b1);
    rstn = 1'b0;
    #1;
    chk1("arst_recv", bus.dmem_recv, 1'b0);
    chk1("arst_derr", bus.dmem_err, 1'b0);
    rstn = 1'b1;
    model_reset();
    clr_inputs();
    @(negedge clk);

    // async reset while locked on dmem
    bus.dmem_req  = 1'b1;
    bus.dmem_addr = 64'h5000;
    step();
    bus.imem_req  = 1'b1;
    bus.imem_addr = 64'h6000;
    #1;
    chk64("arst_lockd_addr", bus.m_addr, 64'h5000);
    rstn = 1'b0;
    bus.dmem_req = 1'b0;
    #1;
    chk1("arst_idle_req", bus.m_req, 1'b1);
    chk64("arst_idle_addr", bus.m_addr, 64'h6000);
    rstn = 1'b1;
    model_reset();
    clr_inputs();
    @(negedge clk);

    // randomized traffic honouring the requester rules
    do_reset();
    pend_i = 1'b0;
    pend_d = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pend_d) begin
        bus.dmem_req   = ($urandom_range(0, 2) != 0);
        bus.dmem_wen   = 1'($urandom_range(0, 1));
        bus.dmem_strb  = 8'($urandom);
        bus.dmem_addr  = {$urandom, $urandom};
        bus.dmem_wdata = {$urandom, $urandom};
      end
      if (pend_i) begin
        if ($urandom_range(0, 9) == 0) bus.imem_req = 1'b0;
      end else begin
        bus.imem_req  = ($urandom_range(0, 3) != 0);
        bus.imem_addr = {$urandom, $urandom};
      end
      bus.m_gnt   = ($urandom_range(0, 2) != 0);
      bus.m_err   = 1'($urandom_range(0, 1));
      bus.m_rdata = {$urandom, $urandom};
      step();
      pend_d = bus.dmem_req && !e_dg;
      pend_i = bus.imem_req && !e_ig;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares the single core memory port between the instruction fetch requester (read-only) and the data load/store requester.
- Sits between the fetch/memory pipeline stages and the memory bus; it is the owner of the req/gnt sequencing on that bus.
- Arbitrates each transaction and locks the selection until the grant.
- Routes the one-cycle-later response back to the requester that owns it.
- Prevents fetch starvation under sustained data traffic.

Parameters:
- ADDR_W, 64, address width in bits (MEM_ADDR_R = ADDR_W-1).
- DATA_W, 64, data width in bits (MEM_DATA_R = DATA_W-1).
- STARVE_LIMIT, 4, consecutive lost contentions after which fetch wins; legal range 1..15.

Ports:
- g_clk  in  1  global clock.
- g_resetn  in  1  global reset, asynchronous, active-low.
- imem_req  in  1  fetch request; held with imem_addr until imem_gnt; may be withdrawn.
- imem_addr  in  ADDR_W  fetch address.
- imem_gnt  out  1  fetch request accepted this cycle.
- imem_err  out  1  fetch response error, valid the cycle after imem_gnt.
- imem_rdata  out  DATA_W  fetch response data.
- dmem_req  in  1  data request; must be held until dmem_gnt.
- dmem_wen  in  1  write enable.
- dmem_strb  in  DATA_W/8  write byte strobes.
- dmem_addr  in  ADDR_W  data address.
- dmem_wdata  in  DATA_W  write data.
- dmem_gnt  out  1  data request accepted.
- dmem_recv  out  1  data response valid.
- dmem_err  out  1  data response error.
- dmem_rdata  out  DATA_W  data response data.
- m_req  out  1  bus request.
- m_wen  out  1  bus write enable.
- m_strb  out  DATA_W/8  bus strobes.
- m_addr  out  ADDR_W  bus address.
- m_wdata  out  DATA_W  bus write data.
- m_gnt  in  1  bus accepted request.
- m_err  in  1  bus response error; valid the cycle after m_gnt.
- m_rdata  in  DATA_W  bus response data.

Behaviour:
- **FSM states:** IDLE, LOCK_I, LOCK_D. Reset state is IDLE.
- **IDLE selection:**
  - Only one req high: select that requester.
  - Both high: select dmem, unless starve_cnt == STARVE_LIMIT, in which case select imem.
- **Locked states:** LOCK_I selects imem only; LOCK_D selects dmem only.
- **Bus drive (combinational):**
  - m_req = selected req.
  - m_addr, m_wen, m_strb, m_wdata come from the selected requester; imem selection forces m_wen = 0 and m_strb = 0.
  - Nothing selected: all m_* outputs are 0.
- **Grant:** x_gnt = m_gnt && x selected && x_req. Zero-cycle path from m_gnt.
- **Transitions:**
  - IDLE with m_req && !m_gnt: go to LOCK_x for the selected x.
  - LOCK_x with m_gnt: go to IDLE.
  - LOCK_I with imem_req low (fetch withdrawal, e.g. control-flow change): go to IDLE; m_req is low that cycle.
  - LOCK_D with dmem_req low is a protocol violation: go to IDLE, no other recovery.
- **starve_cnt:** width 4.
  - Increments, saturating at STARVE_LIMIT, on each dmem_gnt while imem_req is high.
  - Clears on imem_gnt or when imem_req is low.
- **Response tracking:** rsp_v <= m_req && m_gnt; rsp_own <= selected (0 = imem, 1 = dmem).
- **Response routing:**
  - imem_rdata = dmem_rdata = m_rdata, unconditionally.
  - imem_err = m_err && rsp_v && !rsp_own.
  - dmem_recv = rsp_v && rsp_own.
  - dmem_err = m_err && dmem_recv.
- **Back-to-back:** a new grant may occur in the same cycle as the previous response; each response is routed by its own registered rsp_own.
- **Reset values:** state IDLE, starve_cnt 0, rsp_v 0, rsp_own 0. All outputs are 0 when both reqs are low after reset.
- **Reset mid-operation:** asynchronous clear at any point, including in LOCK_x or with rsp_v high. Any pending response is dropped: no recv or err is asserted after reset.

Optional Feature:
- Macro: CORE_MEM_ARB_RR_EN.
- **Defined:** contention in IDLE is resolved round-robin. Register last_own (reset 1 = dmem) is updated on every grant; on contention the requester not equal to last_own wins. starve_cnt and STARVE_LIMIT are unused; the counter is not instantiated.
- **Undefined:** fixed dmem priority with the starvation override, as described above.

Test Plan:
- Fetch alone: imem_req=1, imem_addr=0x80000000, m_gnt=1 → m_addr=0x80000000, m_wen=0, imem_gnt=1. Next cycle m_err=1 → imem_err=1, dmem_recv=0.
- Contention: both reqs high, m_gnt=1 every cycle, STARVE_LIMIT=4 → dmem granted on cycles 0-3, imem on cycle 4, dmem on cycle 5. With CORE_MEM_ARB_RR_EN: grants are I, D, I, D, ...
- Lock hold: dmem write (addr 0x1000, strb 0xFF) with m_gnt=0 for 3 cycles; imem_req raised in cycle 1 → m_addr stays 0x1000 and state stays LOCK_D; after m_gnt, imem is granted next.
- Fetch withdrawal: LOCK_I, imem_req drops → m_req=0 the same cycle, state IDLE. A pending dmem_req is then granted the following cycle.
- Back-to-back routing: imem granted in cycle N, dmem granted in cycle N+1 → imem_err gated by m_err in N+1; dmem_recv=1 in N+2 only.
- Async reset: assert g_resetn=0 mid-LOCK_D with rsp_v=1 → state IDLE immediately, dmem_recv=0, starve_cnt=0, no clock edge needed.
